// File: rtl/pdp11_operand_fetch_if.sv
// Register-file and memory-read bus shared by the operand-fetch unit and its environment.
// master = fetch unit side, slave = register file / memory side.
interface pdp11_operand_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [2:0]        rf_raddr;
  logic [ADDR_W-1:0] rf_rdata;
  logic              rf_we;
  logic [2:0]        rf_waddr;
  logic [ADDR_W-1:0] rf_wdata;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output rf_raddr, rf_we, rf_waddr, rf_wdata, mem_req, mem_addr,
    input  rf_rdata, mem_ack, mem_rdata
  );

  modport slave (
    input  rf_raddr, rf_we, rf_waddr, rf_wdata, mem_req, mem_addr,
    output rf_rdata, mem_ack, mem_rdata
  );
endinterface

// File: rtl/pdp11_operand_fetch.sv
// PDP-11 operand fetch: resolves source/destination operands over all addressing modes,
// performing auto-inc/dec register writes, extension-word reads and PC advance.
module pdp11_operand_fetch #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MAX_OPS = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  two_op,
  input  logic                  byte_op,
  input  logic [2:0]            src_mode,
  input  logic [2:0]            src_reg,
  input  logic [2:0]            dst_mode,
  input  logic [2:0]            dst_reg,
  input  logic [ADDR_W-1:0]     pc_in,
  pdp11_operand_fetch_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_W-1:0]     src_val,
  output logic [DATA_W-1:0]     dst_val,
  output logic [ADDR_W-1:0]     src_ea,
  output logic [ADDR_W-1:0]     dst_ea,
  output logic                  src_is_mem,
  output logic                  dst_is_mem,
  output logic [ADDR_W-1:0]     pc_out
);

  typedef enum logic [2:0] {S_IDLE, S_DEC, S_EXT, S_PTR, S_DATA, S_DONE} state_t;
  state_t state, nxt;

  logic              cur, two_r, byte_r, gap;
  logic [2:0]        sm, sr, dm, dr;
  logic [ADDR_W-1:0] pc, addr;

  logic [2:0]        mode, rn;
  logic [ADDR_W-1:0] rv, step, newv, ext_base;
  logic              last, mem_state, odd_fault, acked, two_eff, auto_mod;
  logic [DATA_W-1:0] reg_val, mem_val;

  function automatic logic [DATA_W-1:0] byte_lane(input logic [DATA_W-1:0] w, input logic hi);
    return {{(DATA_W-8){1'b0}}, (hi ? w[15:8] : w[7:0])};
  endfunction

  assign two_eff = (MAX_OPS > 1) ? two_op : 1'b0;

  always_comb begin
    rn        = cur ? dr : sr;
    mode      = cur ? dm : sm;
    rv        = (rn == 3'd7) ? pc : bus.rf_rdata;
    // Deferred modes always step by a word; byte steps only apply to R0-R5.
    step      = (byte_r && rn < 3'd6 && mode != 3'd3 && mode != 3'd5) ? ADDR_W'(1) : ADDR_W'(2);
    newv      = mode[2] ? rv - step : rv + step;
    ext_base  = (rn == 3'd7) ? pc + ADDR_W'(2) : bus.rf_rdata;
    auto_mod  = (mode >= 3'd2) && (mode <= 3'd5);
    last      = cur || !two_r;
    mem_state = (state == S_EXT) || (state == S_PTR) || (state == S_DATA);
    odd_fault = mem_state && addr[0] && !((state == S_DATA) && byte_r);
    acked     = bus.mem_req && bus.mem_ack;
    reg_val   = byte_r ? byte_lane(rv, 1'b0) : rv;
    mem_val   = byte_r ? byte_lane(bus.mem_rdata, addr[0]) : bus.mem_rdata;
  end

  assign bus.mem_req  = mem_state && !gap && !odd_fault;
  assign bus.mem_addr = {addr[ADDR_W-1:1], 1'b0};
  assign bus.rf_raddr = rn;
  assign bus.rf_waddr = rn;
  assign bus.rf_we    = (state == S_DEC) && (rn != 3'd7) && auto_mod;
  assign bus.rf_wdata = bus.rf_we ? newv : '0;
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign pc_out       = pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (start) nxt = S_DEC;
      S_DEC: begin
        case (mode)
          3'd0:       nxt = last ? S_DONE : S_DEC;
          3'd3, 3'd5: nxt = S_PTR;
          3'd6, 3'd7: nxt = S_EXT;
          default:    nxt = S_DATA;
        endcase
      end
      S_EXT: begin
        if (odd_fault)  nxt = S_DONE;
        else if (acked) nxt = mode[0] ? S_PTR : S_DATA;
      end
      S_PTR: begin
        if (odd_fault)  nxt = S_DONE;
        else if (acked) nxt = S_DATA;
      end
      S_DATA: begin
        if (odd_fault)  nxt = S_DONE;
        else if (acked) nxt = last ? S_DONE : S_DEC;
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur        <= 1'b0;
      two_r      <= 1'b0;
      byte_r     <= 1'b0;
      gap        <= 1'b0;
      sm         <= '0;
      sr         <= '0;
      dm         <= '0;
      dr         <= '0;
      pc         <= '0;
      addr       <= '0;
      err        <= 1'b0;
      src_val    <= '0;
      dst_val    <= '0;
      src_ea     <= '0;
      dst_ea     <= '0;
      src_is_mem <= 1'b0;
      dst_is_mem <= 1'b0;
    end else begin
      // gap forces mem_req low for the cycle after each acknowledged read
      gap <= acked;
      if (odd_fault) err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc         <= pc_in;
            cur        <= !two_eff;
            two_r      <= two_eff;
            byte_r     <= byte_op;
            sm         <= src_mode;
            sr         <= src_reg;
            dm         <= dst_mode;
            dr         <= dst_reg;
            err        <= 1'b0;
            src_val    <= '0;
            dst_val    <= '0;
            src_ea     <= '0;
            dst_ea     <= '0;
            src_is_mem <= 1'b0;
            dst_is_mem <= 1'b0;
          end
        end
        S_DEC: begin
          if (rn == 3'd7 && auto_mod) pc <= newv;
          addr <= mode[2] ? (mode[1] ? pc : newv) : rv;
          if (mode == 3'd0) begin
            if (cur) dst_val <= reg_val;
            else     src_val <= reg_val;
            if (!last) cur <= 1'b1;
          end
        end
        S_EXT: begin
          if (acked) begin
            pc   <= pc + ADDR_W'(2);
            addr <= ext_base + bus.mem_rdata;
          end
        end
        S_PTR: if (acked) addr <= bus.mem_rdata;
        S_DATA: begin
          if (acked) begin
            if (cur) begin
              dst_val    <= mem_val;
              dst_ea     <= addr;
              dst_is_mem <= 1'b1;
            end else begin
              src_val    <= mem_val;
              src_ea     <= addr;
              src_is_mem <= 1'b1;
            end
            if (!last) cur <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pdp11_operand_fetch.sv
// Directed bench for pdp11_operand_fetch with a register-file model and a memory
// responder whose acknowledge delay is adjustable.
module tb_pdp11_operand_fetch;
  logic        clk, reset_n, start, two_op, byte_op;
  logic [2:0]  src_mode, src_reg, dst_mode, dst_reg;
  logic [15:0] pc_in;
  logic        busy, done, err, src_is_mem, dst_is_mem;
  logic [15:0] src_val, dst_val, src_ea, dst_ea, pc_out;

  pdp11_operand_fetch_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  pdp11_operand_fetch #(.ADDR_W(16), .DATA_W(16), .MAX_OPS(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .two_op(two_op), .byte_op(byte_op),
    .src_mode(src_mode), .src_reg(src_reg), .dst_mode(dst_mode), .dst_reg(dst_reg),
    .pc_in(pc_in), .bus(bus), .busy(busy), .done(done), .err(err),
    .src_val(src_val), .dst_val(dst_val), .src_ea(src_ea), .dst_ea(dst_ea),
    .src_is_mem(src_is_mem), .dst_is_mem(dst_is_mem), .pc_out(pc_out)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem [0:32767];
  logic [15:0] rf [0:7];
  logic [15:0] wlog [0:63];
  int          wr_total = 0, req_total = 0, wcnt = 0, ack_wait = 0;
  logic [15:0] last_addr = '0;
  logic        odd_seen = 1'b0;
  logic        poke = 1'b0;
  logic [2:0]  poke_idx = '0;
  logic [15:0] poke_val = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.rf_rdata = rf[bus.rf_raddr];

  // register file writes and bus activity log
  always @(posedge clk) begin
    if (poke) rf[poke_idx] <= poke_val;
    if (bus.rf_we) begin
      rf[bus.rf_waddr] <= bus.rf_wdata;
      wlog[wr_total % 64] <= bus.rf_wdata;
      wr_total <= wr_total + 1;
    end
    if (bus.mem_req) begin
      req_total <= req_total + 1;
      last_addr <= bus.mem_addr;
      if (bus.mem_addr[0]) odd_seen <= 1'b1;
    end
  end

  // memory responder: acknowledges after ack_wait extra cycles of request
  always @(negedge clk) begin
    if (bus.mem_req && bus.mem_ack !== 1'b1) begin
      if (wcnt >= ack_wait) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem[bus.mem_addr[15:1]];
        wcnt = 0;
      end else begin
        bus.mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      bus.mem_ack = 1'b0;
      if (!bus.mem_req) wcnt = 0;
    end
  end

  task automatic set_reg(input int idx, input logic [15:0] v);
    @(negedge clk);
    poke_idx = idx[2:0];
    poke_val = v;
    poke = 1'b1;
    @(negedge clk);
    poke = 1'b0;
  endtask

  task automatic set_mem(input logic [15:0] a, input logic [15:0] v);
    mem[a[15:1]] = v;
  endtask

  task automatic launch(input logic t, input logic b, input logic [2:0] sm, input logic [2:0] sr,
                        input logic [2:0] dm, input logic [2:0] dr, input logic [15:0] pc,
                        output int cyc, output bit to);
    @(negedge clk);
    two_op = t; byte_op = b; src_mode = sm; src_reg = sr; dst_mode = dm; dst_reg = dr;
    pc_in = pc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (done === 1'b1) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    vectors++; if ({busy, done, err, bus.mem_req, bus.rf_we} !== 5'b0) begin miscompares++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, err, bus.mem_req, bus.rf_we}); end
    vectors++; if ({src_val, dst_val, src_ea, dst_ea, pc_out} !== 80'h0) begin miscompares++; $display("FAIL reset_data: got %h want 0", {src_val, dst_val, src_ea, dst_ea, pc_out}); end
    vectors++; if (bus.mem_addr !== 16'h0) begin miscompares++; $display("FAIL reset_addr: got %o want 0", bus.mem_addr); end
  endtask

  task automatic test_mode0;
    int cyc; bit to; int r0;
    set_reg(3, 16'o1234);
    r0 = req_total;
    launch(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd3, 16'o200, cyc, to);
    vectors++; if (to || cyc != 2) begin miscompares++; $display("FAIL mode0_latency: got %0d (timeout %0d) want 2", cyc, to); end
    vectors++; if (dst_val !== 16'o1234) begin miscompares++; $display("FAIL mode0_val: got %o want 1234", dst_val); end
    vectors++; if (dst_is_mem !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL mode0_flags: got is_mem=%b err=%b want 0 0", dst_is_mem, err); end
    vectors++; if (req_total != r0) begin miscompares++; $display("FAIL mode0_noreq: got %0d requests want 0", req_total - r0); end
    vectors++; if (pc_out !== 16'o200) begin miscompares++; $display("FAIL mode0_pc: got %o want 200", pc_out); end
    @(negedge clk);
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL mode0_pulse: got done=%b busy=%b want 0 0", done, busy); end
    vectors++; if (dst_val !== 16'o1234) begin miscompares++; $display("FAIL mode0_hold: got %o want 1234", dst_val); end
  endtask

  task automatic test_autoinc_pair;
    int cyc; bit to; int w0;
    set_reg(0, 16'o1000);
    set_mem(16'o1000, 16'o111);
    set_mem(16'o1002, 16'o222);
    w0 = wr_total;
    launch(1'b1, 1'b0, 3'd2, 3'd0, 3'd2, 3'd0, 16'o300, cyc, to);
    vectors++; if (to) begin miscompares++; $display("FAIL pair_timeout: got no done want done"); end
    vectors++; if (src_ea !== 16'o1000 || dst_ea !== 16'o1002) begin miscompares++; $display("FAIL pair_ea: got %o,%o want 1000,1002", src_ea, dst_ea); end
    vectors++; if (src_val !== 16'o111 || dst_val !== 16'o222) begin miscompares++; $display("FAIL pair_val: got %o,%o want 111,222", src_val, dst_val); end
    vectors++; if (wr_total - w0 != 2) begin miscompares++; $display("FAIL pair_wcount: got %0d want 2", wr_total - w0); end
    vectors++; if (wlog[w0 % 64] !== 16'o1002 || wlog[(w0 + 1) % 64] !== 16'o1004) begin miscompares++; $display("FAIL pair_wdata: got %o,%o want 1002,1004", wlog[w0 % 64], wlog[(w0 + 1) % 64]); end
    vectors++; if (src_is_mem !== 1'b1 || dst_is_mem !== 1'b1) begin miscompares++; $display("FAIL pair_is_mem: got %b%b want 11", src_is_mem, dst_is_mem); end
  endtask

  task automatic test_immediate;
    int cyc; bit to; int w0;
    set_mem(16'o2002, 16'o777);
    w0 = wr_total;
    launch(1'b1, 1'b0, 3'd2, 3'd7, 3'd0, 3'd3, 16'o2002, cyc, to);
    vectors++; if (to) begin miscompares++; $display("FAIL imm_timeout: got no done want done"); end
    vectors++; if (src_val !== 16'o777 || src_ea !== 16'o2002) begin miscompares++; $display("FAIL imm_src: got val=%o ea=%o want 777 2002", src_val, src_ea); end
    vectors++; if (pc_out !== 16'o2004) begin miscompares++; $display("FAIL imm_pc: got %o want 2004", pc_out); end
    vectors++; if (dst_val !== 16'o1234 || wr_total != w0) begin miscompares++; $display("FAIL imm_dst: got val=%o writes=%0d want 1234 0", dst_val, wr_total - w0); end
  endtask

  task automatic test_relative;
    int cyc; bit to;
    set_mem(16'o100, 16'o20);
    set_mem(16'o122, 16'o55);
    launch(1'b0, 1'b0, 3'd0, 3'd0, 3'd6, 3'd7, 16'o100, cyc, to);
    vectors++; if (to) begin miscompares++; $display("FAIL rel_timeout: got no done want done"); end
    vectors++; if (dst_ea !== 16'o122 || dst_val !== 16'o55) begin miscompares++; $display("FAIL rel_dst: got ea=%o val=%o want 122 55", dst_ea, dst_val); end
    vectors++; if (pc_out !== 16'o102 || err !== 1'b0) begin miscompares++; $display("FAIL rel_pc: got pc=%o err=%b want 102 0", pc_out, err); end
  endtask

  task automatic test_byte;
    int cyc; bit to;
    set_mem(16'o500, 16'hABCD);
    set_reg(1, 16'o501);
    launch(1'b0, 1'b1, 3'd0, 3'd0, 3'd4, 3'd1, 16'o400, cyc, to);
    vectors++; if (to || rf[1] !== 16'o500) begin miscompares++; $display("FAIL byte_r1: got %o (timeout %0d) want 500", rf[1], to); end
    vectors++; if (last_addr !== 16'o500 || dst_ea !== 16'o500) begin miscompares++; $display("FAIL byte_addr: got addr=%o ea=%o want 500 500", last_addr, dst_ea); end
    vectors++; if (dst_val !== 16'h00CD) begin miscompares++; $display("FAIL byte_lo: got %h want 00cd", dst_val); end
    set_reg(6, 16'o502);
    launch(1'b0, 1'b1, 3'd0, 3'd0, 3'd4, 3'd6, 16'o400, cyc, to);
    vectors++; if (to || rf[6] !== 16'o500 || dst_val !== 16'h00CD) begin miscompares++; $display("FAIL byte_sp: got r6=%o val=%h want 500 00cd", rf[6], dst_val); end
    set_reg(2, 16'o501);
    launch(1'b0, 1'b1, 3'd0, 3'd0, 3'd1, 3'd2, 16'o400, cyc, to);
    vectors++; if (to || cyc != 3) begin miscompares++; $display("FAIL byte_latency: got %0d want 3", cyc); end
    vectors++; if (dst_val !== 16'h00AB || last_addr !== 16'o500 || dst_ea !== 16'o501) begin miscompares++; $display("FAIL byte_hi: got val=%h addr=%o ea=%o want 00ab 500 501", dst_val, last_addr, dst_ea); end
  endtask

  task automatic test_odd_word;
    int cyc; bit to; int r0;
    set_reg(2, 16'o1001);
    r0 = req_total;
    launch(1'b0, 1'b0, 3'd0, 3'd0, 3'd1, 3'd2, 16'o600, cyc, to);
    vectors++; if (to || err !== 1'b1) begin miscompares++; $display("FAIL odd_err: got err=%b (timeout %0d) want 1", err, to); end
    vectors++; if (req_total != r0) begin miscompares++; $display("FAIL odd_noreq: got %0d requests want 0", req_total - r0); end
    launch(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd2, 16'o600, cyc, to);
    vectors++; if (to || err !== 1'b0 || dst_val !== 16'o1001) begin miscompares++; $display("FAIL odd_clear: got err=%b val=%o want 0 1001", err, dst_val); end
  endtask

  task automatic test_deferred_wait;
    int cyc; bit to;
    set_reg(4, 16'o2000);
    set_mem(16'o1776, 16'o3000);
    set_mem(16'o3000, 16'o4321);
    ack_wait = 2;
    launch(1'b0, 1'b0, 3'd0, 3'd0, 3'd5, 3'd4, 16'o700, cyc, to);
    ack_wait = 0;
    vectors++; if (to || rf[4] !== 16'o1776) begin miscompares++; $display("FAIL defer_r4: got %o want 1776", rf[4]); end
    vectors++; if (dst_ea !== 16'o3000 || dst_val !== 16'o4321) begin miscompares++; $display("FAIL defer_dst: got ea=%o val=%o want 3000 4321", dst_ea, dst_val); end
  endtask

  task automatic test_index_absolute;
    int cyc; bit to;
    set_reg(5, 16'o100);
    set_mem(16'o4000, 16'o20);
    set_mem(16'o120, 16'o6000);
    set_mem(16'o6000, 16'o1357);
    set_mem(16'o4002, 16'o7000);
    set_mem(16'o7000, 16'o2461);
    launch(1'b1, 1'b0, 3'd7, 3'd5, 3'd3, 3'd7, 16'o4000, cyc, to);
    vectors++; if (to || src_ea !== 16'o6000 || src_val !== 16'o1357) begin miscompares++; $display("FAIL idx_src: got ea=%o val=%o want 6000 1357", src_ea, src_val); end
    vectors++; if (dst_ea !== 16'o7000 || dst_val !== 16'o2461) begin miscompares++; $display("FAIL abs_dst: got ea=%o val=%o want 7000 2461", dst_ea, dst_val); end
    vectors++; if (pc_out !== 16'o4004) begin miscompares++; $display("FAIL idx_pc: got %o want 4004", pc_out); end
  endtask

  task automatic test_stall_reset;
    set_reg(2, 16'o1000);
    ack_wait = 1000;
    @(negedge clk);
    two_op = 1'b0; byte_op = 1'b0; dst_mode = 3'd1; dst_reg = 3'd2; pc_in = 16'o1100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      vectors++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'o1000) begin miscompares++; $display("FAIL stall_%0d: got req=%b addr=%o want 1 1000", i, bus.mem_req, bus.mem_addr); end
      if (i == 2) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    #1 reset_n = 1'b0;
    #1;
    vectors++; if (bus.mem_req !== 1'b0 || busy !== 1'b0 || bus.rf_we !== 1'b0) begin miscompares++; $display("FAIL stall_reset: got req=%b busy=%b we=%b want 0 0 0", bus.mem_req, busy, bus.rf_we); end
    ack_wait = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; two_op = 1'b0; byte_op = 1'b0;
    src_mode = '0; src_reg = '0; dst_mode = '0; dst_reg = '0; pc_in = '0;
    repeat (3) @(negedge clk);
    test_reset;
    reset_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_mode0;
    test_autoinc_pair;
    test_immediate;
    test_relative;
    test_byte;
    test_odd_word;
    test_deferred_wait;
    test_index_absolute;
    test_stall_reset;
    test_mode0;
    vectors++; if (odd_seen !== 1'b0) begin miscompares++; $display("FAIL even_addr: got odd mem_addr seen=%b want 0", odd_seen); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
